// File: rtl/pc_fetch_gen.sv
// Program-counter generator for the instruction-fetch valid/ready port with trap > jr > br redirects.
// Optional macro MISALIGN_CHK_EN: misaligned redirect targets are replaced by TRAP_VECTOR and flagged.
module pc_fetch_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INST_BYTES   = 4,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    output logic            o_fetch_valid,
    input  logic            i_fetch_ready,
    output logic [XLEN-1:0] o_fetch_pc,
    output logic            o_fetch_flush,
    output logic [XLEN-1:0] o_pc_plus_inc,
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_br_base,
    input  logic [XLEN-1:0] i_br_imm,
    input  logic            i_jr_valid,
    input  logic [XLEN-1:0] i_jr_rs1,
    input  logic [XLEN-1:0] i_jr_imm,
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_pc,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_misalign
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_PEND
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_pending;
    logic            r_fetch_valid;

    logic [XLEN-1:0] w_br_tgt;
    logic [XLEN-1:0] w_jr_tgt;
    logic [XLEN-1:0] w_sel_tgt;
    logic [XLEN-1:0] w_target;
    logic            w_redirect;
    logic            w_bad_align;
    logic            w_hs;
    logic            w_busy;

    assign w_br_tgt   = i_br_base + i_br_imm;
    assign w_jr_tgt   = (i_jr_rs1 + i_jr_imm) & ~XLEN'(1);
    assign w_redirect = i_trap_valid | i_jr_valid | i_br_taken;

    always_comb begin
        w_sel_tgt = w_br_tgt;
        if (i_trap_valid)
            w_sel_tgt = i_trap_pc;
        else if (i_jr_valid)
            w_sel_tgt = w_jr_tgt;
    end

`ifdef MISALIGN_CHK_EN
    assign w_bad_align = |(w_sel_tgt & XLEN'(INST_BYTES - 1));
    assign o_misalign  = w_redirect & w_bad_align & (r_state != S_BOOT);
`else
    assign w_bad_align = 1'b0;
    assign o_misalign  = 1'b0;
`endif

    assign w_target      = w_bad_align ? TRAP_VECTOR : w_sel_tgt;
    assign o_redirect_pc = w_sel_tgt;
    assign o_pc_plus_inc = r_fetch_pc + XLEN'(INST_BYTES);
    assign o_fetch_pc    = r_fetch_pc;
    assign o_fetch_valid = r_fetch_valid;

    assign w_hs   = r_fetch_valid & i_fetch_ready;
    assign w_busy = r_fetch_valid & ~i_fetch_ready;

    // Flush marks the stale request in the very cycle memory accepts it.
    assign o_fetch_flush = (r_state == S_PEND) & i_fetch_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_BOOT;
            r_fetch_pc    <= RESET_VECTOR;
            r_pending     <= '0;
            r_fetch_valid <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state       <= S_RUN;
                    r_fetch_valid <= ~i_stall;
                end
                S_RUN: begin
                    if (w_redirect && w_busy) begin
                        r_pending <= w_target;
                        r_state   <= S_PEND;
                    end else begin
                        if (w_redirect)
                            r_fetch_pc <= w_target;
                        else if (w_hs)
                            r_fetch_pc <= o_pc_plus_inc;
                        if (!w_busy)
                            r_fetch_valid <= ~i_stall;
                    end
                end
                S_PEND: begin
                    if (w_redirect)
                        r_pending <= w_target;
                    if (i_fetch_ready) begin
                        r_fetch_pc    <= w_redirect ? w_target : r_pending;
                        r_state       <= S_RUN;
                        r_fetch_valid <= ~i_stall;
                    end
                end
                default: begin
                    r_state       <= S_BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
